// File: rtl/tcp_pkg.sv
// tcp_pkg: shared TCP TX types.
//   tx_ctrl_t - control code a socket engine asks the TX header controller to emit
//   sock_id_t - socket index, sized for the largest supported socket count (16)
package tcp_pkg;
   localparam int MAX_SOCKETS = 16;
   typedef enum logic [2:0] {
      TX_CTRL_NONE         = 3'd0,
      TX_CTRL_SEND_SYN     = 3'd1,
      TX_CTRL_SEND_SYN_ACK = 3'd2,
      TX_CTRL_SEND_ACK     = 3'd3,
      TX_CTRL_SEND_FIN     = 3'd4,
      TX_CTRL_SEND_RST     = 3'd5,
      TX_CTRL_SEND_DATA    = 3'd6
   } tx_ctrl_t;
   typedef logic [$clog2(MAX_SOCKETS)-1:0] sock_id_t;
endpackage

// File: rtl/tcp_rr_pick.sv
// tcp_rr_pick: combinational round-robin pick.
//   req - request vector, one bit per socket
//   ptr - highest-priority socket index for this pick
//   win - first requesting socket at or after ptr, wrapping
//   any - at least one request present
module tcp_rr_pick
   import tcp_pkg::*;
#(
   parameter int NUM_SOCKETS = 4
) (
   input  logic [NUM_SOCKETS-1:0] req,
   input  sock_id_t               ptr,
   output sock_id_t               win,
   output logic                   any
);
   logic [NUM_SOCKETS-1:0] rot;
   sock_id_t off;
   logic [4:0] sum;
   always_comb begin
      // rotate so bit 0 is the socket at ptr, then take the lowest set bit
      rot = NUM_SOCKETS'({req, req} >> ptr);
      off = '0;
      for (int i = NUM_SOCKETS - 1; i >= 0; i--) off = rot[i] ? sock_id_t'(i) : off;
      sum = {1'b0, ptr} + {1'b0, off};
      win = sock_id_t'(sum >= 5'(NUM_SOCKETS) ? sum - 5'(NUM_SOCKETS) : sum);
      any = |req;
   end
endmodule

// File: rtl/tcp_tx_arb.sv
// tcp_tx_arb: round-robin arbiter giving socket engines turns at the shared TX header controller.
//   i_clk, i_rst                  - clock, synchronous active-high reset
//   i_req_ctrl, i_req_valid       - per-socket control code and request valid
//   o_req_ack                     - per-socket accept pulse, same cycle as i_tx_ctrl_ack
//   o_tx_ctrl, o_tx_ctrl_valid    - forwarded request to the shared controller
//   i_tx_ctrl_ack                 - shared controller accepts the request
//   o_sock_id                     - granted socket index
//   i_packet_done                 - shared datapath finished the granted packet
//   o_busy                        - a socket holds the grant
//   o_timeout                     - watchdog abort pulse
// Optional feature: define TCP_TX_ARB_TIMEOUT_EN to build the busy watchdog.
module tcp_tx_arb
   import tcp_pkg::*;
#(
   parameter int NUM_SOCKETS    = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                             i_clk,
   input  logic                             i_rst,
   input  tx_ctrl_t [NUM_SOCKETS-1:0]       i_req_ctrl,
   input  logic     [NUM_SOCKETS-1:0]       i_req_valid,
   output logic     [NUM_SOCKETS-1:0]       o_req_ack,
   output tx_ctrl_t                         o_tx_ctrl,
   output logic                             o_tx_ctrl_valid,
   input  logic                             i_tx_ctrl_ack,
   output sock_id_t                         o_sock_id,
   input  logic                             i_packet_done,
   output logic                             o_busy,
   output logic                             o_timeout
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_BUSY  = 2'd2;
   localparam int IW = $clog2(NUM_SOCKETS);
   logic [1:0] state;
   sock_id_t grant_id, last_grant, start, win;
   logic any, in_grant, in_busy, timeout_hit;
   logic [IW-1:0] gi;
   assign gi       = grant_id[IW-1:0];
   assign in_grant = state == S_GRANT;
   assign in_busy  = state == S_BUSY;
   assign start    = (last_grant == sock_id_t'(NUM_SOCKETS - 1)) ? '0 : last_grant + 1'b1;
   tcp_rr_pick #(.NUM_SOCKETS(NUM_SOCKETS)) u_pick (
      .req (i_req_valid),
      .ptr (start),
      .win (win),
      .any (any)
   );
`ifdef TCP_TX_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   logic [CW-1:0] cnt;
   // cleared while in GRANT so the first BUSY cycle sees zero
   always_ff @(posedge i_clk)
      if (i_rst || in_grant) cnt <= '0;
      else if (in_busy) cnt <= cnt + 1'b1;
   assign timeout_hit = in_busy && cnt == CW'(TIMEOUT_CYCLES - 1) && !i_packet_done;
`else
   assign timeout_hit = 1'b0;
`endif
   always_ff @(posedge i_clk)
      if (i_rst) begin
         state      <= S_IDLE;
         grant_id   <= '0;
         last_grant <= sock_id_t'(NUM_SOCKETS - 1);
      end else begin
         case (state)
            S_IDLE:
               if (any) begin
                  grant_id <= win;
                  state    <= S_GRANT;
               end
            S_GRANT:
               if (i_tx_ctrl_ack) begin
                  last_grant <= grant_id;
                  state      <= S_BUSY;
               end else if (!i_req_valid[gi]) state <= S_IDLE;
            S_BUSY:
               if (i_packet_done) state <= S_IDLE;
               else if (timeout_hit) begin
                  last_grant <= grant_id;
                  state      <= S_IDLE;
               end
            default: state <= S_IDLE;
         endcase
      end
   // outputs are masked by i_rst so a reset landing in GRANT/BUSY never leaks an ack
   assign o_tx_ctrl_valid = in_grant && !i_rst;
   assign o_tx_ctrl       = o_tx_ctrl_valid ? i_req_ctrl[gi] : TX_CTRL_NONE;
   assign o_req_ack       = (o_tx_ctrl_valid && i_tx_ctrl_ack) ? NUM_SOCKETS'(1) << gi : '0;
   assign o_busy          = (in_grant || in_busy) && !i_rst;
   assign o_sock_id       = o_busy ? grant_id : '0;
   assign o_timeout       = timeout_hit && !i_rst;
endmodule

// File: tb/tb_tcp_tx_arb.sv
// tb_tcp_tx_arb: directed bench for tcp_tx_arb with a transaction-level reference model.
module tb_tcp_tx_arb;
   import tcp_pkg::*;
   localparam int N  = 4;
   localparam int TO = 16;
`ifdef TCP_TX_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   tx_ctrl_t [N-1:0] req_ctrl = '{default: TX_CTRL_NONE};
   logic [N-1:0] req_valid = '0;
   logic tx_ack = 1'b0;
   logic done = 1'b0;
   logic [N-1:0] req_ack;
   tx_ctrl_t tx_ctrl;
   logic tx_valid, busy, timeout;
   sock_id_t sock_id;

   tcp_tx_arb #(.NUM_SOCKETS(N), .TIMEOUT_CYCLES(TO)) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_req_ctrl      (req_ctrl),
      .i_req_valid     (req_valid),
      .o_req_ack       (req_ack),
      .o_tx_ctrl       (tx_ctrl),
      .o_tx_ctrl_valid (tx_valid),
      .i_tx_ctrl_ack   (tx_ack),
      .o_sock_id       (sock_id),
      .i_packet_done   (done),
      .o_busy          (busy),
      .o_timeout       (timeout)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int grants[$];
   int to_count = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // model: owner = socket holding the grant (-1 none), acked = controller took it
   int owner = -1;
   bit acked = 1'b0;
   int busy_cnt = 0;
   int last = N - 1;

   always @(posedge clk) begin
      if (rst) begin
         owner = -1;
         acked = 1'b0;
         last  = N - 1;
      end else if (owner < 0) begin
         for (int k = 1; k <= N; k++)
            if (owner < 0 && req_valid[(last + k) % N]) owner = (last + k) % N;
         acked = 1'b0;
      end else if (!acked) begin
         if (tx_ack) begin
            acked    = 1'b1;
            last     = owner;
            busy_cnt = 0;
         end else if (!req_valid[owner]) owner = -1;
      end else begin
         if (done) owner = -1;
         else if (TO_EN && busy_cnt == TO - 1) owner = -1;
         else busy_cnt++;
      end
   end

   always @(negedge clk) begin
      int e_ack, e_ctrl, e_sock, e_val, e_busy, e_to;
      e_ack = 0; e_ctrl = 0; e_sock = 0; e_val = 0; e_busy = 0; e_to = 0;
      if (!rst && owner >= 0) begin
         e_busy = 1;
         e_sock = owner;
         if (!acked) begin
            e_val  = 1;
            e_ctrl = int'(req_ctrl[owner]);
            e_ack  = tx_ack ? (1 << owner) : 0;
         end else e_to = (TO_EN && busy_cnt == TO - 1 && !done) ? 1 : 0;
      end
      chk("req_ack", int'(req_ack), e_ack);
      chk("tx_ctrl", int'(tx_ctrl), e_ctrl);
      chk("tx_valid", int'(tx_valid), e_val);
      chk("sock_id", int'(sock_id), e_sock);
      chk("busy", int'(busy), e_busy);
      chk("timeout", int'(timeout), e_to);
      if (req_ack != '0) grants.push_back(int'(sock_id));
      if (timeout) to_count++;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic serve(input int busy_cycles);
      int n = 0;
      while (!tx_valid && n < 50) begin
         tick();
         n++;
      end
      chk("serve_wait", n < 50 ? 1 : 0, 1);
      tx_ack = 1'b1;
      tick();
      tx_ack = 1'b0;
      repeat (busy_cycles) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
   endtask

   initial begin
      int exp_rr[5] = '{0, 1, 2, 3, 0};
      repeat (3) tick();
      rst = 1'b0;
      // stray done in IDLE
      done = 1'b1;
      tick();
      done = 1'b0;
      // single request from socket 2, ack two cycles after grant, stray done in ack cycle
      req_ctrl[2] = TX_CTRL_SEND_SYN;
      req_valid = 4'b0100;
      tick();
      tick();
      tx_ack = 1'b1;
      done = 1'b1;
      @(negedge clk);
      chk("single_sock", int'(sock_id), 2);
      chk("single_ack", int'(req_ack), 4);
      chk("single_ctrl", int'(tx_ctrl), int'(TX_CTRL_SEND_SYN));
      tick();
      tx_ack = 1'b0;
      done = 1'b0;
      req_valid = '0;
      @(negedge clk);
      chk("single_in_busy", int'(busy), 1);
      chk("single_valid_low", int'(tx_valid), 0);
      repeat (3) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      @(negedge clk);
      chk("single_idle", int'(busy), 0);
      chk("single_ack_count", grants.size(), 1);
      chk("single_ack_id", grants.size() > 0 ? grants[0] : -1, 2);
      // fairness from reset with all sockets requesting
      grants.delete();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req_ctrl = '{TX_CTRL_SEND_FIN, TX_CTRL_SEND_DATA, TX_CTRL_SEND_ACK, TX_CTRL_SEND_SYN_ACK};
      req_valid = 4'b1111;
      for (int i = 0; i < 5; i++) serve(1);
      for (int i = 0; i < 5; i++)
         chk($sformatf("rr_order%0d", i), i < grants.size() ? grants[i] : -1, exp_rr[i]);
      // abandon: socket 1 drops valid in GRANT, socket 2 wins next
      req_valid = 4'b0010;
      tick();
      req_valid = 4'b0100;
      tick();
      tick();
      @(negedge clk);
      chk("abandon_sock", int'(sock_id), 2);
      chk("abandon_valid", int'(tx_valid), 1);
      chk("abandon_no_ack", grants.size(), 5);
      serve(0);
      req_valid = '0;
      chk("abandon_grant", grants.size() == 6 ? grants[5] : -1, 2);
      // reset mid-BUSY, then socket 0 wins; reset in GRANT with ack raised
      req_valid = 4'b0010;
      tick();
      tx_ack = 1'b1;
      tick();
      tx_ack = 1'b0;
      req_valid = 4'b1011;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy_low", int'(busy), 0);
      tick();
      @(negedge clk);
      chk("rst_next_sock", int'(sock_id), 0);
      chk("rst_next_valid", int'(tx_valid), 1);
      rst = 1'b1;
      tx_ack = 1'b1;
      tick();
      rst = 1'b0;
      tx_ack = 1'b0;
      req_valid = '0;
      @(negedge clk);
      chk("rst_grant_no_ack", grants.size(), 7);
      // watchdog: no packet_done
      req_valid = 4'b1000;
      tick();
      tx_ack = 1'b1;
      tick();
      tx_ack = 1'b0;
      req_valid = '0;
      repeat (20) tick();
      @(negedge clk);
      chk("to_busy", int'(busy), TO_EN ? 0 : 1);
      chk("to_pulses", to_count, TO_EN ? 1 : 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
